// File: rtl/safe_lock_pkg.sv
// Shared definitions for the safe-lock keypad front end: key codes,
// the 4x4 key map and the scanner / entry state encodings.
package safe_lock_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKOUT} entry_state_e;
  typedef enum logic [1:0] {SCAN, PRESS_DB, RELEASE_WAIT} scan_state_e;

  // Physical layout: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = KEY_A;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = KEY_B;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = 4'h0;
      4'hE: k = KEY_HASH;
      4'hF: k = KEY_D;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
    logic [1:0] r;
    if (!row[0])      r = 2'd0;
    else if (!row[1]) r = 2'd1;
    else if (!row[2]) r = 2'd2;
    else              r = 2'd3;
    return r;
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 matrix scanner with press/release debounce; emits one key_valid
// pulse per debounced press and holds the last key code.
module keypad_scan
  import safe_lock_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       row_sel_q, row_sel_d;
  logic [3:0]       row_smp_q, row_smp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       row_meta_q, row_s_q;

  // Rows come straight off the keypad; the two-flop delay is shorter than
  // any column dwell, so the dwell-end sample still belongs to this column.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_sel_d   = row_sel_q;
    row_smp_d   = row_smp_q;
    cnt_d       = cnt_q + 1'b1;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (&row_s_q) begin
            idx_d = idx_q + 2'd1;
          end else begin
            state_d   = PRESS_DB;
            row_smp_d = row_s_q;
            row_sel_d = lowest_low_row(row_s_q);
          end
        end
      end
      PRESS_DB: begin
        if (row_s_q != row_smp_q) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = RELEASE_WAIT;
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = key_map(row_sel_q, idx_q);
        end
      end
      RELEASE_WAIT: begin
        if (!(&row_s_q)) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
    col_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      idx_q       <= 2'd0;
      row_sel_q   <= 2'd0;
      row_smp_q   <= 4'hF;
      cnt_q       <= '0;
      col_q       <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_sel_q   <= row_sel_d;
      row_smp_q   <= row_smp_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      row_meta_q  <= row;
      row_s_q     <= row_meta_q;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_code_entry.sv
// Safe-lock code entry: buffers digits from the keypad scanner, checks the
// code on '#', and runs the open / lockout timers.
module keypad_code_entry
  import safe_lock_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int MAX_TRIES       = 3,
  parameter int OPEN_CYCLES     = 50000000,
  parameter int LOCKOUT_CYCLES  = 100000000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [3:0]              col,
  input  logic [3:0]              row,
  input  logic [4*NUM_DIGITS-1:0] code_set,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic [3:0]              digit_cnt,
  output logic                    unlocked,
  output logic                    alarm,
  output logic [1:0]              fail_cnt
);

  localparam int BUF_W   = 4 * NUM_DIGITS;
  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]       ND        = 4'(NUM_DIGITS);
  localparam logic [1:0]       TRIES     = 2'(MAX_TRIES);

  logic       kv;
  logic [3:0] kc;

  keypad_scan #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_valid(kv),
    .key_code (kc)
  );

  entry_state_e     state_q, state_d;
  logic [BUF_W-1:0] code_buf_q, code_buf_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic             unl_q, unl_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       fail_q, fail_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       fail_inc;
  logic             match;

  assign fail_inc = fail_q + 2'd1;
  assign match    = (dcnt_q == ND) && (code_buf_q == code_set);

  // The verdict is registered on the '#' cycle so unlocked/alarm appear the
  // very next cycle; CHECK then just routes on the registered result.
  always_comb begin
    state_d    = state_q;
    code_buf_d = code_buf_q;
    dcnt_d     = dcnt_q;
    unl_d      = unl_q;
    alarm_d    = alarm_q;
    fail_d     = fail_q;
    tmr_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (kv) begin
          if (is_digit(kc)) begin
            if (dcnt_q < ND) begin
              code_buf_d = (code_buf_q << 4) | BUF_W'(kc);
              dcnt_d     = dcnt_q + 4'd1;
            end
          end else if (kc == KEY_STAR) begin
            code_buf_d = '0;
            dcnt_d     = '0;
          end else if (kc == KEY_HASH) begin
            state_d    = CHECK;
            code_buf_d = '0;
            dcnt_d     = '0;
            if (match) begin
              unl_d  = 1'b1;
              fail_d = '0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == TRIES) alarm_d = 1'b1;
            end
          end
        end
      end
      CHECK: begin
        if (unl_q)        state_d = OPEN;
        else if (alarm_q) state_d = LOCKOUT;
        else              state_d = IDLE;
      end
      OPEN: begin
        tmr_d = tmr_q + 1'b1;
        if ((kv && kc == KEY_STAR) || tmr_q == OPEN_LAST) begin
          state_d = IDLE;
          unl_d   = 1'b0;
        end
      end
      LOCKOUT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == LOCK_LAST) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          fail_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      code_buf_q <= '0;
      dcnt_q     <= '0;
      unl_q      <= 1'b0;
      alarm_q    <= 1'b0;
      fail_q     <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_buf_q <= code_buf_d;
      dcnt_q     <= dcnt_d;
      unl_q      <= unl_d;
      alarm_q    <= alarm_d;
      fail_q     <= fail_d;
      tmr_q      <= tmr_d;
    end
  end

  assign key_valid = kv;
  assign key_code  = kc;
  assign digit_cnt = dcnt_q;
  assign unlocked  = unl_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: a keypad model drives rows from the column
// strobe; a time-stamped lock model predicts the status outputs.
module tb_keypad_code_entry;
  localparam int ND = 4, SC = 4, DB = 8, OC = 100, LC = 200, MT = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  col, row, key_code, digit_cnt;
  logic [15:0] code_set = 16'h1234;
  logic        key_valid, unlocked, alarm;
  logic [1:0]  fail_cnt;

  int total = 0, bad = 0, cyc = 0, kv_cnt = 0, last_tk = 0;
  logic pressed = 1'b0, glitch = 1'b0;
  int pr = 0, pc = 0;

  // lock model: buffered digits, failures, open/lockout end edges
  int m_q[$];
  int m_fail = 0, m_open_end = 0, m_lock_end = 0;
  bit m_open = 0, m_lock = 0;

  keypad_code_entry #(
    .NUM_DIGITS(ND), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB),
    .MAX_TRIES(MT), .OPEN_CYCLES(OC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst_n), .col(col), .row(row), .code_set(code_set),
    .key_valid(key_valid), .key_code(key_code), .digit_cnt(digit_cnt),
    .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (key_valid) kv_cnt++;

  always_comb begin
    row = 4'hF;
    if (glitch) row[2] = 1'b0;
    if (pressed && col[pc] == 1'b0) row[pr] = 1'b0;
  end

  task automatic key_rc(input int k, output int r, output int c);
    case (k)
      1: begin r = 0; c = 0; end   2: begin r = 0; c = 1; end
      3: begin r = 0; c = 2; end  10: begin r = 0; c = 3; end
      4: begin r = 1; c = 0; end   5: begin r = 1; c = 1; end
      6: begin r = 1; c = 2; end  11: begin r = 1; c = 3; end
      7: begin r = 2; c = 0; end   8: begin r = 2; c = 1; end
      9: begin r = 2; c = 2; end  12: begin r = 2; c = 3; end
      14: begin r = 3; c = 0; end  0: begin r = 3; c = 1; end
      15: begin r = 3; c = 2; end default: begin r = 3; c = 3; end
    endcase
  endtask

  task automatic model_reset();
    m_q.delete(); m_fail = 0; m_open = 0; m_lock = 0;
  endtask

  task automatic model_key(input int k, input int tk);
    bit ok;
    if (m_open && tk > m_open_end) m_open = 0;
    if (m_lock && tk > m_lock_end) begin m_lock = 0; m_fail = 0; end
    if (m_open) begin
      if (k == 14 || tk == m_open_end) m_open = 0;
    end else if (m_lock) begin
      if (tk == m_lock_end) begin m_lock = 0; m_fail = 0; end
    end else if (k <= 9) begin
      if (m_q.size() < ND) m_q.push_back(k);
    end else if (k == 14) begin
      m_q.delete();
    end else if (k == 15) begin
      ok = (m_q.size() == ND);
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i] != int'((code_set >> (4 * (ND - 1 - i))) & 16'hF)) ok = 0;
      m_q.delete();
      if (ok) begin m_open = 1; m_open_end = tk + OC + 1; m_fail = 0; end
      else begin
        m_fail++;
        if (m_fail == MT) begin m_lock = 1; m_lock_end = tk + LC + 1; end
      end
    end
  endtask

  task automatic check_status(input string tag);
    int s = cyc;
    logic eu, ea;
    logic [1:0] ef;
    logic [3:0] ed;
    eu = m_open && s < m_open_end;
    ea = m_lock && s < m_lock_end;
    ef = (m_lock && s >= m_lock_end) ? 2'd0 : 2'(m_fail);
    ed = 4'(m_q.size());
    total++; if (unlocked !== eu) begin $display("FAIL %s unlocked got=%b exp=%b", tag, unlocked, eu); bad++; end
    total++; if (alarm !== ea) begin $display("FAIL %s alarm got=%b exp=%b", tag, alarm, ea); bad++; end
    total++; if (fail_cnt !== ef) begin $display("FAIL %s fail_cnt got=%0d exp=%0d", tag, fail_cnt, ef); bad++; end
    total++; if (digit_cnt !== ed) begin $display("FAIL %s digit_cnt got=%0d exp=%0d", tag, digit_cnt, ed); bad++; end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k, input int hold);
    int r, c, kv0;
    bit seen = 0;
    kv0 = kv_cnt;
    key_rc(k, r, c);
    @(negedge clk); pr = r; pc = c; pressed = 1'b1;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (key_valid) seen = 1;
    end
    total++;
    if (!seen) begin $display("FAIL key_timeout key=%0h got=none exp=pulse", k); bad++; end
    else begin
      total++; if (key_code !== 4'(k)) begin $display("FAIL key_code got=%0h exp=%0h", key_code, k); bad++; end
      @(posedge clk); #1;
      last_tk = cyc;
      model_key(k, cyc);
      check_status("after_key");
      repeat (hold) @(negedge clk);
      total++; if (col !== ~(4'b0001 << c)) begin $display("FAIL col_frozen got=%b exp=%b", col, ~(4'b0001 << c)); bad++; end
    end
    pressed = 1'b0;
    repeat (DB + 6) @(negedge clk);
    total++; if (kv_cnt !== kv0 + 1) begin $display("FAIL one_event key=%0h got=%0d exp=1", k, kv_cnt - kv0); bad++; end
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) press_key(keys[i], $urandom_range(1, 6));
  endtask

  task automatic test_reset();
    total++; if (col !== 4'b1110) begin $display("FAIL reset_col got=%b exp=1110", col); bad++; end
    total++; if (key_valid !== 1'b0) begin $display("FAIL reset_kv got=%b exp=0", key_valid); bad++; end
    total++; if (key_code !== 4'h0) begin $display("FAIL reset_code got=%0h exp=0", key_code); bad++; end
    check_status("reset");
  endtask

  task automatic test_scan_5();
    press_key(5, 40);
  endtask

  task automatic test_glitch();
    int kv0 = kv_cnt;
    logic [3:0] c0;
    bit moved = 0;
    @(negedge clk); glitch = 1'b1;
    repeat (3) @(negedge clk);
    glitch = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (kv_cnt !== kv0) begin $display("FAIL glitch_event got=%0d exp=0", kv_cnt - kv0); bad++; end
    c0 = col;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (col !== c0) moved = 1; end
    total++; if (!moved) begin $display("FAIL scan_resume got=stuck exp=moving col=%b", col); bad++; end
    check_status("glitch");
  endtask

  task automatic test_unlock_timeout();
    int t0;
    press_seq('{14, 1, 2, 3, 4, 15});
    t0 = last_tk;
    total++; if (unlocked !== 1'b1) begin $display("FAIL unlock got=%b exp=1", unlocked); bad++; end
    wait_until(t0 + OC - 5);
    total++; if (unlocked !== 1'b1) begin $display("FAIL open_hold got=%b exp=1", unlocked); bad++; end
    wait_until(t0 + OC + 5);
    total++; if (unlocked !== 1'b0) begin $display("FAIL open_timeout got=%b exp=0", unlocked); bad++; end
    check_status("timeout");
  endtask

  task automatic test_star_relock();
    press_seq('{1, 2, 3, 4, 15, 14});
    total++; if (unlocked !== 1'b0) begin $display("FAIL star_relock got=%b exp=0", unlocked); bad++; end
  endtask

  task automatic test_wrong();
    press_seq('{1, 2, 3, 15});
    total++; if (fail_cnt !== 2'd1) begin $display("FAIL short_code got=%0d exp=1", fail_cnt); bad++; end
    press_seq('{9, 9, 9, 9, 15});
    total++; if (fail_cnt !== 2'd2) begin $display("FAIL wrong_code got=%0d exp=2", fail_cnt); bad++; end
    total++; if (digit_cnt !== 4'd0) begin $display("FAIL wrong_clear got=%0d exp=0", digit_cnt); bad++; end
  endtask

  task automatic test_lockout();
    int t0;
    press_seq('{5, 5, 5, 5, 15});
    t0 = last_tk;
    total++; if (alarm !== 1'b1) begin $display("FAIL lockout got=%b exp=1", alarm); bad++; end
    for (int i = 1; i <= 4; i++) press_key(i, 1);
    press_key(15, 1);
    total++; if (unlocked !== 1'b0) begin $display("FAIL lock_ignore got=%b exp=0", unlocked); bad++; end
    wait_until(t0 + LC + 5);
    total++; if (alarm !== 1'b0) begin $display("FAIL lock_end got=%b exp=0", alarm); bad++; end
    check_status("lock_end");
    press_seq('{14, 1, 2, 3, 4, 15});
    total++; if (unlocked !== 1'b1) begin $display("FAIL post_lock_unlock got=%b exp=1", unlocked); bad++; end
    press_key(14, 2);
  endtask

  task automatic test_star_clear();
    press_seq('{14, 1, 2, 14, 1, 2, 3, 4, 5, 15});
    total++; if (unlocked !== 1'b1) begin $display("FAIL star_clear got=%b exp=1", unlocked); bad++; end
    press_key(14, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) press_seq('{1, 2, 3, 4, 15});
      else press_key($urandom_range(0, 15), $urandom_range(1, 12));
      repeat ($urandom_range(0, 120)) @(negedge clk);
      check_status("random");
    end
  endtask

  task automatic test_reset_mid();
    press_seq('{1, 2});
    @(negedge clk); #2 rst_n = 1'b0; #1;
    model_reset();
    test_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_scan_5();
    test_glitch();
    test_unlock_timeout();
    test_star_relock();
    test_wrong();
    test_lockout();
    test_star_clear();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
